// File: rtl/apb_arbiter.sv
// Two-master APB arbiter with round-robin tie-break, replaying the winner's transfer as SETUP->ACCESS.
// Optional macro APB_TIMEOUT_EN aborts an ACCESS phase that stalls for TIMEOUT_CYCLES cycles.
module apb_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rts_n,
  input  logic                    m0_psel,
  input  logic                    m0_penable,
  input  logic                    m0_pwrite,
  input  logic [ADDR_WIDTH-1:0]   m0_paddr,
  input  logic [DATA_WIDTH-1:0]   m0_pdata,
  input  logic [DATA_WIDTH/8-1:0] m0_pstb,
  output logic [DATA_WIDTH-1:0]   m0_prdata,
  output logic                    m0_pready,
  output logic                    m0_perr,
  input  logic                    m1_psel,
  input  logic                    m1_penable,
  input  logic                    m1_pwrite,
  input  logic [ADDR_WIDTH-1:0]   m1_paddr,
  input  logic [DATA_WIDTH-1:0]   m1_pdata,
  input  logic [DATA_WIDTH/8-1:0] m1_pstb,
  output logic [DATA_WIDTH-1:0]   m1_prdata,
  output logic                    m1_pready,
  output logic                    m1_perr,
  output logic                    s_psel,
  output logic                    s_penable,
  output logic                    s_pwrite,
  output logic [ADDR_WIDTH-1:0]   s_paddr,
  output logic [DATA_WIDTH-1:0]   s_pdata,
  output logic [DATA_WIDTH/8-1:0] s_pstb,
  input  logic [DATA_WIDTH-1:0]   s_prdata,
  input  logic                    s_pready,
  input  logic                    s_perr,
  output logic [1:0]              grant
);
  localparam int STB_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [1:0]            r_grant;
  logic                  r_last_grant;
  logic                  r_drop;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [DATA_WIDTH-1:0] r_pdata;
  logic [STB_W-1:0]      r_pstb;

  logic                  w_any_req;
  logic                  w_pick1;
  logic                  w_gnt_psel;
  logic                  w_done;
  logic                  w_timeout;
  logic                  w_end;
  logic                  w_reply;
  logic                  w_win_pwrite;
  logic [ADDR_WIDTH-1:0] w_win_paddr;
  logic [DATA_WIDTH-1:0] w_win_pdata;
  logic [STB_W-1:0]      w_win_pstb;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic                  w_unused;

  // penable is irrelevant to arbitration: a waiting master may already be in its access phase
  assign w_unused = ^{m0_penable, m1_penable};

  assign w_any_req    = m0_psel | m1_psel;
  assign w_pick1      = m1_psel & (~m0_psel | ~r_last_grant);
  assign w_win_pwrite = w_pick1 ? m1_pwrite : m0_pwrite;
  assign w_win_paddr  = w_pick1 ? m1_paddr  : m0_paddr;
  assign w_win_pdata  = w_pick1 ? m1_pdata  : m0_pdata;
  assign w_win_pstb   = w_pick1 ? m1_pstb   : m0_pstb;

  assign w_gnt_psel = (r_grant[0] & m0_psel) | (r_grant[1] & m1_psel);
  assign w_done     = (r_state == ST_ACCESS) & s_pready;
  assign w_end      = w_done | w_timeout;
  // A master that let go of psel during its transfer forfeits the reply
  assign w_reply    = w_end & w_gnt_psel & ~r_drop;
  assign w_rdata    = (w_done && !r_pwrite) ? s_prdata : '0;

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_tmo_cnt;

  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_ACCESS && !s_pready) begin
      r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
    end
  end

  assign w_timeout = (r_state == ST_ACCESS) & ~s_pready &
                     (r_tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign w_timeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:   if (w_any_req) w_state_next = ST_SETUP;
      ST_SETUP:  w_state_next = ST_ACCESS;
      ST_ACCESS: if (w_end) w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rts_n) begin
    if (!rts_n) begin
      r_grant      <= 2'b00;
      r_last_grant <= 1'b1;
      r_drop       <= 1'b0;
      r_pwrite     <= 1'b0;
      r_paddr      <= '0;
      r_pdata      <= '0;
      r_pstb       <= '0;
    end else begin
      if (r_state == ST_IDLE && w_any_req) begin
        r_grant  <= w_pick1 ? 2'b10 : 2'b01;
        r_drop   <= 1'b0;
        r_pwrite <= w_win_pwrite;
        r_paddr  <= w_win_paddr;
        r_pdata  <= w_win_pdata;
        r_pstb   <= w_win_pwrite ? w_win_pstb : '1;
      end else if (r_state != ST_IDLE && !w_gnt_psel) begin
        r_drop <= 1'b1;
      end
      if (w_end) begin
        r_grant      <= 2'b00;
        r_last_grant <= r_grant[1];
      end
    end
  end

  assign s_psel    = (r_state != ST_IDLE);
  assign s_penable = (r_state == ST_ACCESS);
  assign s_pwrite  = r_pwrite;
  assign s_paddr   = r_paddr;
  assign s_pdata   = r_pdata;
  assign s_pstb    = r_pstb;
  assign grant     = r_grant;

  assign m0_pready = w_reply & r_grant[0];
  assign m1_pready = w_reply & r_grant[1];
  assign m0_perr   = m0_pready & (s_perr | w_timeout);
  assign m1_perr   = m1_pready & (s_perr | w_timeout);
  assign m0_prdata = m0_pready ? w_rdata : '0;
  assign m1_prdata = m1_pready ? w_rdata : '0;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: per-cycle vector table plus hand sequences for
// wait states, contention, reset mid-transfer and the optional ACCESS timeout.
module tb_apb_arbiter;
  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  logic        clk = 1'b0;
  logic        rts_n = 1'b0;
  logic        m0_psel = 0, m0_penable = 0, m0_pwrite = 0;
  logic [31:0] m0_paddr = 0, m0_pdata = 0;
  logic [3:0]  m0_pstb = 0;
  logic [31:0] m0_prdata;
  logic        m0_pready, m0_perr;
  logic        m1_psel = 0, m1_penable = 0, m1_pwrite = 0;
  logic [31:0] m1_paddr = 0, m1_pdata = 0;
  logic [3:0]  m1_pstb = 0;
  logic [31:0] m1_prdata;
  logic        m1_pready, m1_perr;
  logic        s_psel, s_penable, s_pwrite;
  logic [31:0] s_paddr, s_pdata;
  logic [3:0]  s_pstb;
  logic [31:0] s_prdata = 0;
  logic        s_pready = 0, s_perr = 0;
  logic [1:0]  grant;

  int checks = 0;
  int errors = 0;

  apb_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rts_n(rts_n),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_pwrite(m0_pwrite),
    .m0_paddr(m0_paddr), .m0_pdata(m0_pdata), .m0_pstb(m0_pstb),
    .m0_prdata(m0_prdata), .m0_pready(m0_pready), .m0_perr(m0_perr),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_pwrite(m1_pwrite),
    .m1_paddr(m1_paddr), .m1_pdata(m1_pdata), .m1_pstb(m1_pstb),
    .m1_prdata(m1_prdata), .m1_pready(m1_pready), .m1_perr(m1_perr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pdata(s_pdata), .s_pstb(s_pstb),
    .s_prdata(s_prdata), .s_pready(s_pready), .s_perr(s_perr),
    .grant(grant)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        p0;
    logic [31:0] a0;
    logic        p1;
    logic [31:0] a1;
    logic        rdy;
    logic        err;
    logic [31:0] rd;
    logic [1:0]  e_grant;
    logic        e_sp;
    logic        e_pe;
    logic [31:0] e_paddr;
    logic        e_r0;
    logic [31:0] e_d0;
    logic        e_r1;
    logic [31:0] e_d1;
    logic        e_err1;
  } vec_t;

  function automatic vec_t mkv(input logic p0, input logic [31:0] a0,
                               input logic p1, input logic [31:0] a1,
                               input logic rdy, input logic err, input logic [31:0] rd,
                               input logic [1:0] g, input logic sp, input logic pe,
                               input logic [31:0] ea, input logic r0, input logic [31:0] d0,
                               input logic r1, input logic [31:0] d1, input logic e1);
    vec_t v;
    v.p0 = p0; v.a0 = a0; v.p1 = p1; v.a1 = a1;
    v.rdy = rdy; v.err = err; v.rd = rd;
    v.e_grant = g; v.e_sp = sp; v.e_pe = pe; v.e_paddr = ea;
    v.e_r0 = r0; v.e_d0 = d0; v.e_r1 = r1; v.e_d1 = d1; v.e_err1 = e1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_psel = 0; m0_penable = 0; m0_pwrite = 0; m0_paddr = 0; m0_pdata = 0; m0_pstb = 0;
    m1_psel = 0; m1_penable = 0; m1_pwrite = 0; m1_paddr = 0; m1_pdata = 0; m1_pstb = 0;
    s_pready = 0; s_perr = 0; s_prdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rts_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rts_n = 1'b1;
  endtask

  vec_t vecs[15];
  logic [1:0] exp_g[6];

  initial begin
    vecs[0]  = mkv(H, 32'h100, H, 32'h200, L, L, 32'h0,        2'b00, L, L, 32'h0,    L, 32'h0,        L, 32'h0,        L);
    vecs[1]  = mkv(H, 32'h100, H, 32'h200, L, L, 32'h0,        2'b01, H, L, 32'h100,  L, 32'h0,        L, 32'h0,        L);
    vecs[2]  = mkv(H, 32'h100, H, 32'h200, H, L, 32'h11111111, 2'b01, H, H, 32'h100,  H, 32'h11111111, L, 32'h0,        L);
    vecs[3]  = mkv(L, 32'h0,   H, 32'h200, H, H, 32'h33333333, 2'b00, L, L, 32'h0,    L, 32'h0,        L, 32'h0,        L);
    vecs[4]  = mkv(L, 32'h0,   H, 32'h200, L, L, 32'h0,        2'b10, H, L, 32'h200,  L, 32'h0,        L, 32'h0,        L);
    vecs[5]  = mkv(L, 32'h0,   H, 32'h200, H, H, 32'h22222222, 2'b10, H, H, 32'h200,  L, 32'h0,        H, 32'h22222222, H);
    vecs[6]  = mkv(L, 32'h0,   L, 32'h0,   L, L, 32'h0,        2'b00, L, L, 32'h0,    L, 32'h0,        L, 32'h0,        L);
    vecs[7]  = mkv(H, 32'h1000, L, 32'h0,  L, L, 32'h0,        2'b00, L, L, 32'h0,    L, 32'h0,        L, 32'h0,        L);
    vecs[8]  = mkv(H, 32'h1000, L, 32'h0,  H, L, 32'hDEADBEEF, 2'b01, H, L, 32'h1000, L, 32'h0,        L, 32'h0,        L);
    vecs[9]  = mkv(H, 32'h1000, L, 32'h0,  H, L, 32'hDEADBEEF, 2'b01, H, H, 32'h1000, H, 32'hDEADBEEF, L, 32'h0,        L);
    vecs[10] = mkv(L, 32'h0,   L, 32'h0,   L, L, 32'h0,        2'b00, L, L, 32'h0,    L, 32'h0,        L, 32'h0,        L);
    vecs[11] = mkv(H, 32'h300, L, 32'h0,   L, L, 32'h0,        2'b00, L, L, 32'h0,    L, 32'h0,        L, 32'h0,        L);
    vecs[12] = mkv(L, 32'h300, L, 32'h0,   L, L, 32'h0,        2'b01, H, L, 32'h300,  L, 32'h0,        L, 32'h0,        L);
    vecs[13] = mkv(L, 32'h300, L, 32'h0,   H, L, 32'h44444444, 2'b01, H, H, 32'h300,  L, 32'h0,        L, 32'h0,        L);
    vecs[14] = mkv(L, 32'h0,   L, 32'h0,   L, L, 32'h0,        2'b00, L, L, 32'h0,    L, 32'h0,        L, 32'h0,        L);
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};

    // Reset state, sampled while rts_n is still low
    idle_inputs();
    #12;
    check("reset_grant", {30'h0, grant}, 32'h0);
    check("reset_s_psel", {31'h0, s_psel}, 32'h0);
    check("reset_s_paddr", s_paddr, 32'h0);
    check("reset_m0_pready", {31'h0, m0_pready}, 32'h0);
    do_reset();

    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      m0_psel = vecs[i].p0; m0_penable = vecs[i].p0; m0_paddr = vecs[i].a0;
      m1_psel = vecs[i].p1; m1_paddr = vecs[i].a1;
      s_pready = vecs[i].rdy; s_perr = vecs[i].err; s_prdata = vecs[i].rd;
      @(negedge clk);
      $display("vec %0d: grant=%b s_psel=%b s_penable=%b s_paddr=%h m0_pready=%b m1_pready=%b",
               i, grant, s_psel, s_penable, s_paddr, m0_pready, m1_pready);
      check($sformatf("v%0d_grant", i), {30'h0, grant}, {30'h0, vecs[i].e_grant});
      check($sformatf("v%0d_s_psel", i), {31'h0, s_psel}, {31'h0, vecs[i].e_sp});
      check($sformatf("v%0d_s_penable", i), {31'h0, s_penable}, {31'h0, vecs[i].e_pe});
      if (vecs[i].e_sp) begin
        check($sformatf("v%0d_s_paddr", i), s_paddr, vecs[i].e_paddr);
        check($sformatf("v%0d_s_pstb", i), {28'h0, s_pstb}, 32'hF);
      end
      check($sformatf("v%0d_m0_pready", i), {31'h0, m0_pready}, {31'h0, vecs[i].e_r0});
      check($sformatf("v%0d_m0_prdata", i), m0_prdata, vecs[i].e_d0);
      check($sformatf("v%0d_m0_perr", i), {31'h0, m0_perr}, 32'h0);
      check($sformatf("v%0d_m1_pready", i), {31'h0, m1_pready}, {31'h0, vecs[i].e_r1});
      check($sformatf("v%0d_m1_prdata", i), m1_prdata, vecs[i].e_d1);
      check($sformatf("v%0d_m1_perr", i), {31'h0, m1_perr}, {31'h0, vecs[i].e_err1});
    end

    // Continuous contention: grants must alternate starting with master 0
    do_reset();
    begin
      int n = 0;
      @(posedge clk); #1;
      m0_psel = 1; m0_paddr = 32'hA0; m1_psel = 1; m1_paddr = 32'hB0;
      s_pready = 1; s_prdata = 32'h12345678;
      for (int c = 0; c < 40 && n < 6; c++) begin
        @(negedge clk);
        if (s_penable) begin
          $display("contention xfer %0d: grant=%b s_paddr=%h", n, grant, s_paddr);
          check($sformatf("cont%0d_grant", n), {30'h0, grant}, {30'h0, exp_g[n]});
          check($sformatf("cont%0d_m0_pready", n), {31'h0, m0_pready}, {31'h0, exp_g[n][0]});
          check($sformatf("cont%0d_m1_pready", n), {31'h0, m1_pready}, {31'h0, exp_g[n][1]});
          check($sformatf("cont%0d_s_paddr", n), s_paddr, exp_g[n][0] ? 32'hA0 : 32'hB0);
          n++;
        end
      end
      check("cont_count", n, 6);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
    end

    // Master 1 write with three wait states
    begin
      int pulses = 0;
      int at_k = -1;
      logic found = 0;
      @(posedge clk); #1;
      m1_psel = 1; m1_penable = 1; m1_pwrite = 1; m1_paddr = 32'h20;
      m1_pdata = 32'h55AA00FF; m1_pstb = 4'b0011; s_prdata = 32'hFFFFFFFF;
      for (int c = 0; c < 5 && !found; c++) begin
        @(negedge clk);
        if (s_psel) found = 1;
      end
      check("wr_setup_seen", {31'h0, found}, 32'h1);
      check("wr_setup_penable", {31'h0, s_penable}, 32'h0);
      check("wr_setup_s_pwrite", {31'h0, s_pwrite}, 32'h1);
      check("wr_setup_s_paddr", s_paddr, 32'h20);
      for (int k = 1; k <= 6; k++) begin
        @(posedge clk); #1;
        m1_pdata = 32'hBAD0BAD0; m1_pstb = 4'b1100;
        s_pready = (k == 4);
        if (k >= 5) m1_psel = 0;
        @(negedge clk);
        if (k <= 4) begin
          check($sformatf("wr_k%0d_s_pstb", k), {28'h0, s_pstb}, 32'h3);
          check($sformatf("wr_k%0d_s_pdata", k), s_pdata, 32'h55AA00FF);
          check($sformatf("wr_k%0d_s_penable", k), {31'h0, s_penable}, 32'h1);
        end
        if (m1_pready) begin
          pulses++;
          at_k = k;
          check("wr_m1_prdata", m1_prdata, 32'h0);
        end
      end
      $display("write xfer: m1_pready pulses=%0d at cycle %0d after SETUP", pulses, at_k);
      check("wr_pulse_count", pulses, 1);
      check("wr_pulse_cycle", at_k, 4);
      idle_inputs();
    end

    // Asynchronous reset in the middle of ACCESS
    begin
      logic found = 0;
      @(posedge clk); #1;
      m0_psel = 1; m0_paddr = 32'h500;
      for (int c = 0; c < 6 && !found; c++) begin
        @(negedge clk);
        if (s_penable) found = 1;
      end
      check("rst_access_seen", {31'h0, found}, 32'h1);
      #1;
      rts_n = 0;
      #1;
      s_pready = 1; s_prdata = 32'h99999999;
      #1;
      $display("reset mid-access: grant=%b s_psel=%b s_penable=%b m0_pready=%b",
               grant, s_psel, s_penable, m0_pready);
      check("rst_s_psel", {31'h0, s_psel}, 32'h0);
      check("rst_s_penable", {31'h0, s_penable}, 32'h0);
      check("rst_grant", {30'h0, grant}, 32'h0);
      check("rst_m0_pready", {31'h0, m0_pready}, 32'h0);
      check("rst_s_paddr", s_paddr, 32'h0);
      @(posedge clk); #1;
      s_pready = 0;
      @(negedge clk);
      rts_n = 1;
      @(negedge clk);
      check("rst_fresh_setup_psel", {31'h0, s_psel}, 32'h1);
      check("rst_fresh_setup_penable", {31'h0, s_penable}, 32'h0);
      check("rst_fresh_grant", {30'h0, grant}, 32'h1);
      @(posedge clk); #1;
      s_pready = 1; s_prdata = 32'h5555AAAA;
      @(negedge clk);
      check("rst_fresh_m0_pready", {31'h0, m0_pready}, 32'h1);
      check("rst_fresh_m0_prdata", m0_prdata, 32'h5555AAAA);
      @(posedge clk); #1;
      idle_inputs();
      @(negedge clk);
    end

    // Slave never ready
    begin
      logic found = 0;
      @(posedge clk); #1;
      m0_psel = 1; m0_paddr = 32'h600; s_prdata = 32'h77777777;
      for (int c = 0; c < 5 && !found; c++) begin
        @(negedge clk);
        if (s_psel) found = 1;
      end
      check("tmo_setup_seen", {31'h0, found}, 32'h1);
`ifdef APB_TIMEOUT_EN
      for (int k = 1; k <= 9; k++) begin
        @(posedge clk); #1;
        if (k == 9) begin
          s_pready = 1;
          m0_psel = 0;
        end
        @(negedge clk);
        check($sformatf("tmo_k%0d_m0_pready", k), {31'h0, m0_pready}, {31'h0, (k == 8)});
        if (k <= 8) check($sformatf("tmo_k%0d_s_penable", k), {31'h0, s_penable}, 32'h1);
        if (k == 8) begin
          $display("timeout abort: m0_pready=%b m0_perr=%b m0_prdata=%h", m0_pready, m0_perr, m0_prdata);
          check("tmo_m0_perr", {31'h0, m0_perr}, 32'h1);
          check("tmo_m0_prdata", m0_prdata, 32'h0);
        end
        if (k == 9) check("tmo_s_psel_dropped", {31'h0, s_psel}, 32'h0);
      end
`else
      begin
        int bad = 0;
        for (int k = 1; k <= 120; k++) begin
          @(negedge clk);
          if (s_psel !== 1'b1 || m0_pready !== 1'b0) bad++;
        end
        $display("no timeout: s_psel held for 120 ACCESS cycles, deviations=%0d", bad);
        check("notmo_psel_held", bad, 0);
      end
`endif
      do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Two-master, one-slave APB arbiter that shares the system APB bus between the cpu (master 0) and a second requester such as a DMA or debug port (master 1).
- Each master drives a full APB master interface. The arbiter picks one master, replays its transfer on the slave side as a clean SETUP→ACCESS sequence, and returns the slave's pready, prdata and perr only to the granted master.
- Ties are broken round-robin.

Parameters:
- ADDR_WIDTH, 32, address width of all paddr ports
- DATA_WIDTH, 32, data width of pdata and prdata ports
- TIMEOUT_CYCLES, 256, ACCESS-phase cycles before abort; used only with APB_TIMEOUT_EN

Ports:
- clk  in  1  system clock, rising edge
- rts_n  in  1  asynchronous active-low reset
- m0_psel, m0_penable, m0_pwrite  in  1 each  master 0 APB controls
- m0_paddr  in  ADDR_WIDTH  master 0 address
- m0_pdata  in  DATA_WIDTH  master 0 write data
- m0_pstb  in  DATA_WIDTH/8  master 0 write byte strobes
- m0_prdata  out  DATA_WIDTH  read data to master 0
- m0_pready, m0_perr  out  1 each  completion and error to master 0
- m1_*  (same nine signals as m0_*)  master 1 interface
- s_psel, s_penable, s_pwrite  out  1 each  slave APB controls
- s_paddr  out  ADDR_WIDTH  slave address
- s_pdata  out  DATA_WIDTH  slave write data
- s_pstb  out  DATA_WIDTH/8  slave byte strobes
- s_prdata  in  DATA_WIDTH  slave read data
- s_pready, s_perr  in  1 each  slave completion and error
- grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- Reset (rts_n=0, asynchronous): state IDLE; every s_* output, grant, and every m*_pready/m*_perr/m*_prdata = 0; last_grant = 1, so master 0 wins the first tie. Reset mid-transfer aborts silently; no pready is ever returned for the aborted transfer.
- Request: mN_psel=1. mN_penable is ignored for arbitration; a master may already sit in its access phase while it waits.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - Only one request: grant that master.
  - Both request: grant the master != last_grant.
  - On grant, register paddr/pdata/pwrite/pstb from the winner, set grant, go to SETUP.
  - Outputs are registered, so s_psel rises one cycle after the request is first seen.
- SETUP: s_psel=1, s_penable=0; always exactly one cycle; go to ACCESS.
- ACCESS: s_psel=1, s_penable=1. Stay while s_pready=0. On s_pready=1 in the same cycle:
  - mN_pready=1 combinationally for the granted master only.
  - mN_prdata = s_prdata (read) or 0 (write).
  - mN_perr = s_perr.
  - Next state IDLE; last_grant updates; grant clears.
- Non-granted master: pready=0, perr=0, prdata=0. It keeps psel high and waits.
- s_paddr, s_pdata and s_pstb hold the captured values for the whole transfer. Master-side changes during the transfer are ignored.
- s_pstb forwards the master strobes on writes and is forced to all-ones on reads.
- Granted master drops psel mid-transfer (APB violation): the slave transfer still completes; the result is discarded and no pready is returned.
- Back-to-back: the cycle after completion is always IDLE, giving a minimum 3-cycle transfer (IDLE, SETUP, ACCESS). Round-robin then guarantees alternation under continuous contention.
- A request asserted in the same cycle as the other master's completion is evaluated in the following IDLE cycle.

Optional Feature:
- Macro: APB_TIMEOUT_EN.
- Enabled: a counter clears on entry to ACCESS and increments each ACCESS cycle with s_pready=0. When it reaches TIMEOUT_CYCLES-1, the arbiter:
  - returns mN_pready=1, mN_perr=1, mN_prdata=0 to the granted master;
  - drops s_psel/s_penable the next cycle;
  - goes to IDLE.
  A late slave pready after an abort is ignored.
- Disabled: no counter exists; ACCESS waits indefinitely.

Test Plan:
- Master 0 read, addr 0x1000, slave ready on first ACCESS cycle with s_prdata=0xDEADBEEF: s_psel at cycle+1, s_penable at cycle+2, m0_pready=1 with m0_prdata=0xDEADBEEF at cycle+2, grant=01.
- Both masters request together after reset: master 0 is served first, then master 1; s_paddr shows m0_paddr then m1_paddr; m1_pready stays 0 until its own ACCESS.
- Continuous contention for 6 transfers: grant sequence 01,10,01,10,01,10.
- Master 1 write 0x55AA00FF to 0x20 with pstb=0011, slave inserts 3 wait states: s_pstb=0011 and s_pdata constant throughout; m1_pready pulses exactly once, 4 cycles after the SETUP cycle.
- rts_n low during ACCESS: all outputs 0 immediately, no mN_pready pulse; the next master 0 request after reset starts a fresh SETUP.
- With APB_TIMEOUT_EN and TIMEOUT_CYCLES=8, slave never ready: m0_perr=1 and m0_pready=1 on the 8th ACCESS cycle, s_psel=0 the cycle after. Without the macro, s_psel stays high for more than 100 cycles.
